// File: rtl/dcache_uncached_resp.sv
// dcache_uncached_resp
// Stands in for the data cache on the uncached path. Takes one request of up
// to two lanes that share tag/index. Each lane becomes a single-beat access on
// an SRAM-like bus, issued one at a time. Both lane results are returned
// together with a single data_ok pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready; addr_ok=1, a request with p0_valid is latched
// P0_REQ  | lane 0 beat presented on the bus, waiting for bus_addr_ok
// P0_WAIT | lane 0 beat accepted, waiting for bus_data_ok
// P1_REQ  | lane 1 beat presented on the bus, waiting for bus_addr_ok
// P1_WAIT | lane 1 beat accepted, waiting for bus_data_ok
// DONE    | data_ok pulse, back to IDLE next cycle
module dcache_uncached_resp #(
   parameter int TAG_WIDTH    = 20,
   parameter int INDEX_WIDTH  = 6,
   parameter int OFFSET_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    p0_valid,
   input  logic                    p1_valid,
   input  logic [2:0]              op,
   input  logic [TAG_WIDTH-1:0]    tag,
   input  logic [INDEX_WIDTH-1:0]  index,
   input  logic [OFFSET_WIDTH-1:0] p0_offset,
   input  logic [OFFSET_WIDTH-1:0] p1_offset,
   input  logic [3:0]              p0_wstrb,
   input  logic [3:0]              p1_wstrb,
   input  logic [31:0]             p0_wdata,
   input  logic [31:0]             p1_wdata,
   input  logic [1:0]              p0_size,
   input  logic [1:0]              p1_size,
   input  logic                    uncached,
   output logic                    addr_ok,
   output logic                    data_ok,
   output logic [31:0]             p0_rdata,
   output logic [31:0]             p1_rdata,
   output logic                    bus_req,
   output logic                    bus_wr,
   output logic [1:0]              bus_size,
   output logic [31:0]             bus_addr,
   output logic [3:0]              bus_wstrb,
   output logic [31:0]             bus_wdata,
   input  logic                    bus_addr_ok,
   input  logic                    bus_data_ok,
   input  logic [31:0]             bus_rdata
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_P0_REQ  = 3'd1,
      S_P0_WAIT = 3'd2,
      S_P1_REQ  = 3'd3,
      S_P1_WAIT = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                  r_state;
   logic                    r_bus_req;
   logic                    r_data_ok;
   logic [31:0]             r_p0_rdata;
   logic [31:0]             r_p1_rdata;

   logic [2:0]              r_op;
   logic [TAG_WIDTH-1:0]    r_tag;
   logic [INDEX_WIDTH-1:0]  r_index;
   logic [OFFSET_WIDTH-1:0] r_p0_offset;
   logic [OFFSET_WIDTH-1:0] r_p1_offset;
   logic [3:0]              r_p0_wstrb;
   logic [3:0]              r_p1_wstrb;
   logic [31:0]             r_p0_wdata;
   logic [31:0]             r_p1_wdata;
   logic [1:0]              r_p0_size;
   logic [1:0]              r_p1_size;
   logic                    r_p1_flag;

   logic                    w_is_read;
   logic                    w_is_write;
   logic                    w_lane1;
   logic [31:0]             w_addr0;
   logic [31:0]             w_addr1;
   // Every request is served uncached, so the hint is deliberately dropped.
   logic                    w_unused;

   assign w_unused   = uncached;
   assign w_is_read  = (r_op == 3'd0);
   assign w_is_write = (r_op == 3'd1);
   assign w_lane1    = (r_state == S_P1_REQ) || (r_state == S_P1_WAIT);
   assign w_addr0    = {r_tag, r_index, r_p0_offset};
   assign w_addr1    = {r_tag, r_index, r_p1_offset};

   // Request FSM: latches the request, sequences the beats, registers results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_bus_req   <= 1'b0;
         r_data_ok   <= 1'b0;
         r_p0_rdata  <= '0;
         r_p1_rdata  <= '0;
         r_op        <= '0;
         r_tag       <= '0;
         r_index     <= '0;
         r_p0_offset <= '0;
         r_p1_offset <= '0;
         r_p0_wstrb  <= '0;
         r_p1_wstrb  <= '0;
         r_p0_wdata  <= '0;
         r_p1_wdata  <= '0;
         r_p0_size   <= '0;
         r_p1_size   <= '0;
         r_p1_flag   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (p0_valid) begin
                  r_op        <= op;
                  r_tag       <= tag;
                  r_index     <= index;
                  r_p0_offset <= p0_offset;
                  r_p1_offset <= p1_offset;
                  r_p0_wstrb  <= p0_wstrb;
                  r_p1_wstrb  <= p1_wstrb;
                  r_p0_wdata  <= p0_wdata;
                  r_p1_wdata  <= p1_wdata;
                  r_p0_size   <= p0_size;
                  r_p1_size   <= p1_size;
                  r_p1_flag   <= p1_valid;
                  // ops other than read/write complete without touching the bus
                  if (op == 3'd0 || op == 3'd1) begin
                     r_state   <= S_P0_REQ;
                     r_bus_req <= 1'b1;
                  end else begin
                     r_state   <= S_DONE;
                     r_data_ok <= 1'b1;
                  end
               end
            end
            S_P0_REQ: begin
               if (bus_addr_ok) begin
                  r_state   <= S_P0_WAIT;
                  r_bus_req <= 1'b0;
               end
            end
            S_P0_WAIT: begin
               if (bus_data_ok) begin
                  if (w_is_read) begin
                     r_p0_rdata <= bus_rdata;
                  end
                  if (r_p1_flag) begin
                     r_state   <= S_P1_REQ;
                     r_bus_req <= 1'b1;
                  end else begin
                     r_state   <= S_DONE;
                     r_data_ok <= 1'b1;
                  end
               end
            end
            S_P1_REQ: begin
               if (bus_addr_ok) begin
                  r_state   <= S_P1_WAIT;
                  r_bus_req <= 1'b0;
               end
            end
            S_P1_WAIT: begin
               if (bus_data_ok) begin
                  if (w_is_read) begin
                     r_p1_rdata <= bus_rdata;
                  end
                  r_state   <= S_DONE;
                  r_data_ok <= 1'b1;
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               r_data_ok <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               r_bus_req <= 1'b0;
               r_data_ok <= 1'b0;
            end
         endcase
      end
   end

   // Bus beat fields come from whichever lane the FSM is currently serving.
   always_comb begin
      bus_wr    = w_is_write;
      bus_addr  = w_addr0;
      bus_size  = r_p0_size;
      bus_wstrb = r_p0_wstrb;
      bus_wdata = r_p0_wdata;
      if (w_lane1) begin
         bus_addr  = w_addr1;
         bus_size  = r_p1_size;
         bus_wstrb = r_p1_wstrb;
         bus_wdata = r_p1_wdata;
      end
   end

   assign addr_ok  = (r_state == S_IDLE);
   assign data_ok  = r_data_ok;
   assign bus_req  = r_bus_req;
   assign p0_rdata = r_p0_rdata;
   assign p1_rdata = r_p1_rdata;

endmodule

// File: tb/tb_dcache_uncached_resp.sv
// tb_dcache_uncached_resp
// Randomized requests against a transaction-level model: each request is
// expanded into the list of bus beats it should produce, and the lane results
// are predicted from the read data the bus responder hands back.
module tb_dcache_uncached_resp;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p0_valid, p1_valid;
   logic [2:0]  op;
   logic [19:0] tag;
   logic [5:0]  index, p0_offset, p1_offset;
   logic [3:0]  p0_wstrb, p1_wstrb;
   logic [31:0] p0_wdata, p1_wdata;
   logic [1:0]  p0_size, p1_size;
   logic        uncached;
   logic        addr_ok, data_ok;
   logic [31:0] p0_rdata, p1_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;

   dcache_uncached_resp #(.TAG_WIDTH(20), .INDEX_WIDTH(6), .OFFSET_WIDTH(6)) dut (
      .clk(clk), .reset(reset),
      .p0_valid(p0_valid), .p1_valid(p1_valid), .op(op), .tag(tag), .index(index),
      .p0_offset(p0_offset), .p1_offset(p1_offset),
      .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb),
      .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
      .p0_size(p0_size), .p1_size(p1_size), .uncached(uncached),
      .addr_ok(addr_ok), .data_ok(data_ok), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } beat_t;

   beat_t       beat_q[$];
   logic [31:0] rdata_fix_q[$];
   int          acc_fix = -1;
   int          rsp_fix = -1;
   int          dok_total = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_rd0 = '0;
   logic [31:0] exp_rd1 = '0;

   task automatic chk(input string tag_s, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag_s, obs, exp_v, $time);
      end
   endtask

   // Bus responder: random accept delay per beat, random data latency.
   initial begin : bus_slave
      bit          req_hold;
      bit          rsp_pending;
      int          acc_cnt;
      int          rsp_cnt;
      logic [31:0] rsp_data;
      beat_t       b;
      req_hold = 0; rsp_pending = 0; acc_cnt = 0; rsp_cnt = 0; rsp_data = '0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
      forever begin
         @(negedge clk);
         bus_addr_ok = 0;
         bus_data_ok = 0;
         if (reset) req_hold = 0;
         else if (req_hold) chk("req_held", bus_req, 1);
         if (rsp_pending) begin
            if (rsp_cnt == 0) begin
               bus_data_ok = 1;
               bus_rdata   = rsp_data;
               rsp_pending = 0;
               dok_total++;
            end else rsp_cnt--;
         end else if (bus_req && !reset) begin
            if (!req_hold) begin
               req_hold = 1;
               acc_cnt  = (acc_fix >= 0) ? acc_fix : int'($urandom_range(0, 3));
            end
            if (acc_cnt == 0) begin
               bus_addr_ok = 1;
               req_hold    = 0;
               rsp_data    = (rdata_fix_q.size() != 0) ? rdata_fix_q.pop_front() : $urandom;
               b.addr = bus_addr; b.wr = bus_wr; b.size = bus_size;
               b.strb = bus_wstrb; b.wdata = bus_wdata; b.rdata = rsp_data;
               beat_q.push_back(b);
               rsp_pending = 1;
               rsp_cnt     = (rsp_fix >= 0) ? rsp_fix : int'($urandom_range(0, 2));
            end else acc_cnt--;
         end
      end
   end

   task automatic scramble_inputs();
      p0_valid = 0; p1_valid = 1'($urandom); op = 3'($urandom);
      tag = 20'($urandom); index = 6'($urandom);
      p0_offset = 6'($urandom); p1_offset = 6'($urandom);
      p0_wstrb = 4'($urandom); p1_wstrb = 4'($urandom);
      p0_wdata = $urandom; p1_wdata = $urandom;
      p0_size = 2'($urandom); p1_size = 2'($urandom);
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while (!addr_ok && cyc < 100) begin @(negedge clk); cyc++; end
      chk("idle_ready", addr_ok, 1);
   endtask

   // Issue one request at a negedge and check the whole transaction.
   task automatic run_req(input bit v0, input bit v1, input int opv,
                          input logic [19:0] tg, input logic [5:0] ix,
                          input logic [5:0] o0, input logic [5:0] o1,
                          input logic [3:0] s0, input logic [3:0] s1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [1:0] z0, input logic [1:0] z1);
      int          cyc;
      bit          done;
      int          nexp;
      int          nchk;
      beat_t       b;
      logic [31:0] ea;
      wait_idle();
      p0_valid = v0; p1_valid = v1; op = 3'(opv); tag = tg; index = ix;
      p0_offset = o0; p1_offset = o1; p0_wstrb = s0; p1_wstrb = s1;
      p0_wdata = d0; p1_wdata = d1; p0_size = z0; p1_size = z1;
      @(negedge clk);
      scramble_inputs();
      if (!v0) begin
         repeat (4) begin
            chk("ign_addr_ok", addr_ok, 1);
            chk("ign_bus_req", bus_req, 0);
            chk("ign_data_ok", data_ok, 0);
            @(negedge clk);
         end
         chk("ign_beats", beat_q.size(), 0);
         chk("ign_rd0", p0_rdata, exp_rd0);
         chk("ign_rd1", p1_rdata, exp_rd1);
         return;
      end
      cyc = 1; done = 0;
      while (!done && cyc < 300) begin
         chk("busy_addr_ok", addr_ok, 0);
         if (data_ok) done = 1;
         else begin @(negedge clk); cyc++; end
      end
      chk("data_ok_seen", 32'(done), 1);
      nexp = (opv == 0 || opv == 1) ? (v1 ? 2 : 1) : 0;
      chk("beat_count", beat_q.size(), nexp);
      nchk = (beat_q.size() < nexp) ? beat_q.size() : nexp;
      for (int i = 0; i < nchk; i++) begin
         b  = beat_q[i];
         ea = tg * 4096 + ix * 64 + ((i == 0) ? o0 : o1);
         chk("beat_addr", b.addr, ea);
         chk("beat_wr", 32'(b.wr), (opv == 1) ? 1 : 0);
         chk("beat_size", 32'(b.size), 32'((i == 0) ? z0 : z1));
         if (opv == 1) begin
            chk("beat_strb", 32'(b.strb), 32'((i == 0) ? s0 : s1));
            chk("beat_wdata", b.wdata, (i == 0) ? d0 : d1);
         end else begin
            if (i == 0) exp_rd0 = b.rdata;
            else        exp_rd1 = b.rdata;
         end
      end
      if (nexp == 0) chk("noop_latency", 32'(cyc <= 2), 1);
      beat_q.delete();
      chk("p0_rdata", p0_rdata, exp_rd0);
      chk("p1_rdata", p1_rdata, exp_rd1);
      @(negedge clk);
      chk("data_ok_single", data_ok, 0);
      chk("ready_after_done", addr_ok, 1);
      chk("no_extra_req", bus_req, 0);
   endtask

   // Reset while lane 0 waits for data; the late bus_data_ok must be ignored.
   task automatic reset_test();
      int cyc;
      int dok0;
      rsp_fix = 8;
      wait_idle();
      p0_valid = 1; p1_valid = 0; op = 3'd0; tag = 20'($urandom); index = 6'($urandom);
      p0_offset = 6'($urandom); p0_size = 2'd2;
      @(negedge clk);
      scramble_inputs();
      cyc = 0;
      while (beat_q.size() == 0 && cyc < 50) begin @(negedge clk); cyc++; end
      chk("rst_beat_issued", beat_q.size(), 1);
      @(posedge clk); #2;
      dok0 = dok_total;
      reset = 1; #1;
      chk("rst_bus_req", bus_req, 0);
      chk("rst_addr_ok", addr_ok, 1);
      chk("rst_data_ok", data_ok, 0);
      chk("rst_rd0", p0_rdata, 0);
      chk("rst_rd1", p1_rdata, 0);
      @(posedge clk); #2;
      reset = 0;
      exp_rd0 = '0; exp_rd1 = '0;
      repeat (12) begin
         @(negedge clk);
         chk("late_data_ok", data_ok, 0);
      end
      chk("late_beat_sent", dok_total - dok0, 1);
      chk("late_rd0", p0_rdata, 0);
      chk("late_addr_ok", addr_ok, 1);
      beat_q.delete();
      rsp_fix = -1;
   endtask

   initial begin
      int r;
      int opv;
      p0_valid = 0; p1_valid = 0; op = '0; tag = '0; index = '0;
      p0_offset = '0; p1_offset = '0; p0_wstrb = '0; p1_wstrb = '0;
      p0_wdata = '0; p1_wdata = '0; p0_size = '0; p1_size = '0; uncached = 1;
      #1;
      chk("reset_addr_ok", addr_ok, 1);
      chk("reset_data_ok", data_ok, 0);
      chk("reset_bus_req", bus_req, 0);
      chk("reset_rd0", p0_rdata, 0);
      chk("reset_rd1", p1_rdata, 0);
      #16 reset = 0;
      @(negedge clk);

      rdata_fix_q.push_back(32'hDEADBEEF);
      run_req(1, 0, 0, 20'h1FC00, 6'h00, 6'h10, 6'h00, 4'hF, 4'h0, 0, 0, 2'd2, 2'd2);
      chk("single_read_data", p0_rdata, 32'hDEADBEEF);

      run_req(1, 1, 1, 20'h12345, 6'h2A, 6'h00, 6'h04, 4'hF, 4'hF,
              32'h11111111, 32'h22222222, 2'd2, 2'd2);

      acc_fix = 3;
      run_req(1, 1, 0, 20'hABCDE, 6'h15, 6'h08, 6'h0C, 4'hF, 4'hF, 0, 0, 2'd2, 2'd2);
      acc_fix = -1;

      run_req(0, 1, 0, 20'h00F0F, 6'h01, 6'h00, 6'h04, 4'hF, 4'hF, 0, 0, 2'd2, 2'd2);
      run_req(1, 1, 3, 20'h00F0F, 6'h01, 6'h00, 6'h04, 4'hF, 4'hF, 0, 0, 2'd2, 2'd2);
      run_req(1, 0, 1, 20'h0BEEF, 6'h3F, 6'h22, 6'h00, 4'h4, 4'h0,
              32'hAABBCCDD, 0, 2'd0, 2'd0);

      reset_test();

      for (int n = 0; n < 60; n++) begin
         r = int'($urandom_range(0, 9));
         opv = (r < 4) ? 0 : (r < 8) ? 1 : int'($urandom_range(2, 7));
         run_req($urandom_range(0, 9) != 0, 1'($urandom), opv,
                 20'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                 4'($urandom), 4'($urandom), $urandom, $urandom,
                 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
